// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath and its issue controller.
// Covers the opcode encoding, controller state encoding and data width.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU. Carry and overflow are only meaningful for ADD and SUB.
// For SUB, carry is the borrow, which is bit 8 of the 9-bit A-B.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow
);

  logic [DATA_W:0] wide_s;

  // Opcode decode and flag generation
  always_comb begin
    wide_s   = {(DATA_W+1){1'b0}};
    result   = {DATA_W{1'b0}};
    carry    = 1'b0;
    overflow = 1'b0;
    case (opcode)
      ADD: begin
        wide_s   = {1'b0, a} + {1'b0, b};
        result   = wide_s[DATA_W-1:0];
        carry    = wide_s[DATA_W];
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      SUB: begin
        wide_s   = {1'b0, a} - {1'b0, b};
        result   = wide_s[DATA_W-1:0];
        carry    = wide_s[DATA_W];
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      NOT:     result = ~a;
      SHL:     result = {a[DATA_W-2:0], 1'b0};
      SHR:     result = {1'b0, a[DATA_W-1:1]};
      default: result = {DATA_W{1'b0}};
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front-end for the 8-bit ALU: registers operands, waits one settle cycle,
// captures result/flags, returns them on a valid/ready response, and keeps accumulator state.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic [DATA_W-1:0] acc,
  output logic              sticky_carry,
  output logic              sticky_overflow,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ISSUE   = ST_ISSUE;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_RESP    = ST_RESP;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_upd_s;
  logic              sticky_carry_q, sticky_carry_d, sticky_carry_upd_s;
  logic              sticky_overflow_q, sticky_overflow_d, sticky_overflow_upd_s;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  // FSM sequencing, operand load, capture and accumulator update
  always_comb begin
    state_d               = state_q;
    alu_a_d               = alu_a_q;
    alu_b_d               = alu_b_q;
    alu_opcode_d          = alu_opcode_q;
    rsp_result_d          = rsp_result_q;
    rsp_carry_d           = rsp_carry_q;
    rsp_zero_d            = rsp_zero_q;
    rsp_overflow_d        = rsp_overflow_q;
    acc_upd_s             = acc_q;
    sticky_carry_upd_s    = sticky_carry_q;
    sticky_overflow_upd_s = sticky_overflow_q;
    op_count_d            = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // acc_q here is the pre-clear value even when acc_clr coincides
          alu_a_d      = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d      = cmd_b;
          alu_opcode_d = cmd_opcode;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_result_d          = alu_result;
        rsp_carry_d           = alu_carry;
        rsp_zero_d            = alu_zero;
        rsp_overflow_d        = alu_overflow;
        acc_upd_s             = alu_result;
        sticky_carry_upd_s    = sticky_carry_q | alu_carry;
        sticky_overflow_upd_s = sticky_overflow_q | alu_overflow;
        state_d               = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Clear takes priority over a coincident capture
    acc_d             = acc_clr ? {DATA_W{1'b0}} : acc_upd_s;
    sticky_carry_d    = acc_clr ? 1'b0 : sticky_carry_upd_s;
    sticky_overflow_d = acc_clr ? 1'b0 : sticky_overflow_upd_s;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      alu_a_q           <= {DATA_W{1'b0}};
      alu_b_q           <= {DATA_W{1'b0}};
      alu_opcode_q      <= 3'b000;
      rsp_result_q      <= {DATA_W{1'b0}};
      rsp_carry_q       <= 1'b0;
      rsp_zero_q        <= 1'b0;
      rsp_overflow_q    <= 1'b0;
      acc_q             <= {DATA_W{1'b0}};
      sticky_carry_q    <= 1'b0;
      sticky_overflow_q <= 1'b0;
      op_count_q        <= {CNT_W{1'b0}};
    end else begin
      state_q           <= state_d;
      alu_a_q           <= alu_a_d;
      alu_b_q           <= alu_b_d;
      alu_opcode_q      <= alu_opcode_d;
      rsp_result_q      <= rsp_result_d;
      rsp_carry_q       <= rsp_carry_d;
      rsp_zero_q        <= rsp_zero_d;
      rsp_overflow_q    <= rsp_overflow_d;
      acc_q             <= acc_d;
      sticky_carry_q    <= sticky_carry_d;
      sticky_overflow_q <= sticky_overflow_d;
      op_count_q        <= op_count_d;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE);
  assign rsp_valid       = (state_q == S_RESP);
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_opcode      = alu_opcode_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_carry       = rsp_carry_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_overflow    = rsp_overflow_q;
  assign acc             = acc_q;
  assign sticky_carry    = sticky_carry_q;
  assign sticky_overflow = sticky_overflow_q;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl wired to alu_8bit, with a scoreboard
// of expected responses built from an independent arithmetic model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode = 3'b000;
  logic [7:0]       cmd_a = 8'h00;
  logic [7:0]       cmd_b = 8'h00;
  logic             cmd_use_acc = 1'b0;
  logic             acc_clr = 1'b0;
  logic [7:0]       alu_a, alu_b, alu_result;
  logic [2:0]       alu_opcode;
  logic             alu_carry, alu_zero, alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic             rsp_carry, rsp_zero, rsp_overflow;
  logic [7:0]       acc;
  logic             sticky_carry, sticky_overflow;
  logic [CNT_W-1:0] op_count;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [7:0] acc_m = 8'h00;
  logic sc_m = 1'b0;
  logic sv_m = 1'b0;
  int   cnt_m = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .acc(acc), .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
    .op_count(op_count)
  );

  alu_8bit u_alu (
    .a(alu_a), .b(alu_b), .opcode(alu_opcode),
    .result(alu_result), .carry(alu_carry), .zero(alu_zero), .overflow(alu_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Integer-arithmetic reference for result and flags
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   u, s;
    e = '{r: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0};
    case (op)
      3'b000: begin
        u = int'(a) + int'(b);
        s = int'($signed(a)) + int'($signed(b));
        e.r = u[7:0];
        e.c = (u > 255);
        e.v = (s > 127) || (s < -128);
      end
      3'b001: begin
        u = int'(a) - int'(b);
        s = int'($signed(a)) - int'($signed(b));
        e.r = u[7:0];
        e.c = (u < 0);
        e.v = (s > 127) || (s < -128);
      end
      3'b010:  e.r = a & b;
      3'b011:  e.r = a | b;
      3'b100:  e.r = a ^ b;
      3'b101:  e.r = ~a;
      3'b110:  e.r = a << 1;
      3'b111:  e.r = a >> 1;
      default: e.r = 8'h00;
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // clr_mode: 0 none, 1 acc_clr with the accept, 2 acc_clr on the CAPTURE edge
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic use_acc, input int hold, input int clr_mode);
    exp_t       e, got;
    logic [7:0] a_eff;
    int         n;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    a_eff = use_acc ? acc_m : a;
    sb_q.push_back(model(op, a_eff, b));
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    acc_clr = (clr_mode == 1);
    @(negedge clk);
    cmd_valid = 1'b0; acc_clr = 1'b0; cmd_a = ~a; cmd_b = ~b;
    if (clr_mode == 1) begin acc_m = 8'h00; sc_m = 1'b0; sv_m = 1'b0; end
    chk("alu_a", {24'd0, alu_a}, {24'd0, a_eff});
    chk("alu_b", {24'd0, alu_b}, {24'd0, b});
    chk("alu_opcode", {29'd0, alu_opcode}, {29'd0, op});
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 8) begin
      acc_clr = (clr_mode == 2) && (n == 1);
      @(negedge clk);
      n++;
    end
    acc_clr = 1'b0;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("latency", n + 1, 32'd3);
    got = '{r: rsp_result, c: rsp_carry, z: rsp_zero, v: rsp_overflow};
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      e = got;
    end else begin
      e = sb_q.pop_front();
    end
    chk("rsp_result", {24'd0, got.r}, {24'd0, e.r});
    chk("rsp_carry", {31'd0, got.c}, {31'd0, e.c});
    chk("rsp_zero", {31'd0, got.z}, {31'd0, e.z});
    chk("rsp_overflow", {31'd0, got.v}, {31'd0, e.v});
    if (clr_mode == 2) begin
      acc_m = 8'h00; sc_m = 1'b0; sv_m = 1'b0;
    end else begin
      acc_m = e.r; sc_m = sc_m | e.c; sv_m = sv_m | e.v;
    end
    chk("acc", {24'd0, acc}, {24'd0, acc_m});
    chk("sticky_carry", {31'd0, sticky_carry}, {31'd0, sc_m});
    chk("sticky_overflow", {31'd0, sticky_overflow}, {31'd0, sv_m});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp", {21'd0, rsp_result, rsp_carry, rsp_zero, rsp_overflow}, {21'd0, e});
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_alu", {13'd0, alu_opcode, alu_a, alu_b}, {13'd0, op, a_eff, b});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cnt_m = (cnt_m + 1) % (1 << CNT_W);
    chk("op_count", {28'd0, op_count}, cnt_m);
    chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_clr();
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    acc_m = 8'h00; sc_m = 1'b0; sv_m = 1'b0;
    chk("clr_acc", {24'd0, acc}, 32'd0);
    chk("clr_sticky", {30'd0, sticky_carry, sticky_overflow}, 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_m = 8'h00; sc_m = 1'b0; sv_m = 1'b0; cnt_m = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_count", {28'd0, op_count}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu", {13'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("rst_rsp", {21'd0, rsp_result, rsp_carry, rsp_zero, rsp_overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Reset while the op sits in CAPTURE: no response, nothing counted
    cmd_valid = 1'b1; cmd_opcode = 3'b000; cmd_a = 8'h11; cmd_b = 8'h22; cmd_use_acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_acc", {24'd0, acc}, 32'd0);
    chk("midrst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("midrst_count", {28'd0, op_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("midrst_count2", {28'd0, op_count}, 32'd0);

    run_op(3'b000, 8'h7F, 8'h01, 1'b0, 0, 0);
    run_op(3'b001, 8'h00, 8'h01, 1'b0, 0, 0);
    chk("sticky_after_sub", {31'd0, sticky_carry}, 32'd1);

    pulse_rst();
    do_clr();
    run_op(3'b000, 8'hEE, 8'h05, 1'b1, 0, 0);
    chk("chain_acc1", {24'd0, acc}, 32'h05);
    run_op(3'b000, 8'hEE, 8'h05, 1'b1, 0, 0);
    chk("chain_acc2", {24'd0, acc}, 32'h0A);
    chk("chain_count", {28'd0, op_count}, 32'd2);

    run_op(3'b100, 8'hAA, 8'hAA, 1'b0, 5, 0);
    run_op(3'b000, 8'h10, 8'h10, 1'b0, 0, 2);
    chk("capclr_acc", {24'd0, acc}, 32'h00);
    run_op(3'b000, 8'hF0, 8'h20, 1'b0, 0, 0);
    run_op(3'b001, 8'h03, 8'h01, 1'b1, 1, 1);

    for (int i = 0; i < 18; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), (i % 5 == 3) ? 1 : 0);
    end
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
